// File: rtl/int_dot_mac_pipe_if.sv
// Operand beat and result handshake bundle for int_dot_mac_pipe.
// slave = MAC side, master = staging/writeback side.
interface int_dot_mac_pipe_if #(
   parameter int LANES = 64,
   parameter int EW    = 4,
   parameter int ACC_W = 24
);
   logic                  clr;
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_first;
   logic                  in_last;
   logic                  in_signed;
   logic [LANES*EW-1:0]   a_vec;
   logic [LANES*EW-1:0]   b_vec;
   logic [ACC_W-1:0]      bias_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_W-1:0]      out_data;
   logic                  out_sat;

   modport slave (
      input  clr, in_valid, in_first, in_last, in_signed, a_vec, b_vec, bias_in, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

   modport master (
      output clr, in_valid, in_first, in_last, in_signed, a_vec, b_vec, bias_in, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/int_dot_mac_pipe.sv
// Pipelined multi-beat integer dot-product MAC with bias and saturating accumulator.
// Result valid two edges after the last beat is accepted; whole pipe stalls while out_valid & !out_ready.
module int_dot_mac_pipe #(
   parameter int LANES = 64,
   parameter int EW    = 4,
   parameter int ACC_W = 24
) (
   input logic               clk,
   input logic               rst,
   int_dot_mac_pipe_if.slave bus
);
   localparam int PW = 2*EW + $clog2(LANES) + 1;
   localparam int XW = 2*EW + 2;
   localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic                 adv;
   logic                 sgn_eff;
   logic signed [EW:0]   ea;
   logic signed [EW:0]   eb;
   logic signed [XW-1:0] prod;
   logic signed [PW-1:0] psum;

   logic                 s1_vld_q, s1_vld_d;
   logic                 s1_first_q, s1_first_d;
   logic                 s1_last_q, s1_last_d;
   logic                 s1_sgn_q, s1_sgn_d;
   logic [PW-1:0]        s1_psum_q, s1_psum_d;
   logic [ACC_W-1:0]     bias_q, bias_d;
   logic                 mode_q, mode_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic                 sat_q, sat_d;
   logic                 out_vld_q, out_vld_d;
   logic [ACC_W-1:0]     out_data_q, out_data_d;
   logic                 out_sat_q, out_sat_d;

   logic [ACC_W:0]       start_x;
   logic [ACC_W:0]       psum_x;
   logic [ACC_W:0]       sum_x;
   logic                 ovf;
   logic [ACC_W-1:0]     clamped;
   logic                 sat_cur;

   assign adv     = !out_vld_q || bus.out_ready;
   assign sgn_eff = bus.in_first ? bus.in_signed : mode_q;

   assign bus.in_ready  = adv;
   assign bus.out_valid = out_vld_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;

   // Elements widened by one bit so unsigned operands stay positive in the signed tree.
   always_comb begin
      psum = '0;
      ea   = '0;
      eb   = '0;
      prod = '0;
      for (int j = 0; j < LANES; j++) begin
         ea   = {sgn_eff & bus.a_vec[j*EW+EW-1], bus.a_vec[j*EW +: EW]};
         eb   = {sgn_eff & bus.b_vec[j*EW+EW-1], bus.b_vec[j*EW +: EW]};
         prod = XW'(ea) * XW'(eb);
         psum = psum + PW'(prod);
      end
   end

   always_comb begin
      if (s1_first_q) start_x = {s1_sgn_q & bias_q[ACC_W-1], bias_q};
      else            start_x = {s1_sgn_q & acc_q[ACC_W-1], acc_q};
      psum_x = {{(ACC_W+1-PW){s1_psum_q[PW-1]}}, s1_psum_q};
      sum_x  = start_x + psum_x;
      // Unsigned operands never go negative, so only the top bit can overflow there.
      if (s1_sgn_q) begin
         ovf     = sum_x[ACC_W] ^ sum_x[ACC_W-1];
         clamped = ovf ? (sum_x[ACC_W] ? SMIN : SMAX) : sum_x[ACC_W-1:0];
      end else begin
         ovf     = sum_x[ACC_W];
         clamped = ovf ? '1 : sum_x[ACC_W-1:0];
      end
      sat_cur = (s1_first_q ? 1'b0 : sat_q) | ovf;
   end

   always_comb begin
      s1_vld_d   = s1_vld_q;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
      s1_sgn_d   = s1_sgn_q;
      s1_psum_d  = s1_psum_q;
      bias_d     = bias_q;
      mode_d     = mode_q;
      acc_d      = acc_q;
      sat_d      = sat_q;
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;
      if (bus.clr) begin
         s1_vld_d  = 1'b0;
         acc_d     = '0;
         sat_d     = 1'b0;
         out_vld_d = 1'b0;
      end else begin
         if (adv) begin
            s1_vld_d = bus.in_valid;
            if (bus.in_valid) begin
               s1_first_d = bus.in_first;
               s1_last_d  = bus.in_last;
               s1_sgn_d   = sgn_eff;
               s1_psum_d  = psum;
               if (bus.in_first) begin
                  bias_d = bus.bias_in;
                  mode_d = bus.in_signed;
               end
            end
         end
         if (out_vld_q && bus.out_ready) out_vld_d = 1'b0;
         if (adv && s1_vld_q) begin
            if (s1_last_q) begin
               out_data_d = clamped;
               out_sat_d  = sat_cur;
               out_vld_d  = 1'b1;
               acc_d      = '0;
               sat_d      = 1'b0;
            end else begin
               acc_d = clamped;
               sat_d = sat_cur;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_sgn_q   <= 1'b0;
         s1_psum_q  <= '0;
         bias_q     <= '0;
         mode_q     <= 1'b0;
         acc_q      <= '0;
         sat_q      <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         s1_sgn_q   <= s1_sgn_d;
         s1_psum_q  <= s1_psum_d;
         bias_q     <= bias_d;
         mode_q     <= mode_d;
         acc_q      <= acc_d;
         sat_q      <= sat_d;
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
      end
   end
endmodule
